// File: rtl/i2c_target_regfile.sv
// I2C target with an 8-bit register file: pointer byte then data bytes on write, auto-increment reads.
// Define I2C_TARGET_GENERAL_CALL_EN to ACK (and discard) general-call writes to address 0x00.
module i2c_target_regfile #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        PW          = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  input  logic [PW-1:0] host_addr,
  output logic [7:0]    host_rdata,
  output logic          busy,
  output logic          wr_strobe,
  output logic [PW-1:0] wr_index,
  output logic          stop_det
);

  // state  | meaning
  // IDLE   | bus free, waiting for START
  // ADDR   | shifting address byte, then ACK slot if addressed
  // PTR    | shifting register-pointer byte, then ACK slot
  // WDATA  | shifting write data, then ACK slot with register write
  // RDATA  | driving read data MSB first
  // RACK   | controller ACK/NACK slot after a read byte
  // IGNORE | not addressed or NACKed, waiting for START/STOP
  typedef enum logic [2:0] {IDLE, ADDR, PTR, WDATA, RDATA, RACK, IGNORE} state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start_cond, stop_cond;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_d;
  assign scl_fall   = ~scl_s & scl_d;
  assign start_cond = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_cond  = scl_s & scl_d & ~sda_d & sda_s;

  logic [7:0] regs [NUM_REGS];
  state_t state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shift, shift_nxt, tx, tx_nxt;
  logic byte_done, byte_done_nxt, ack_phase, ack_phase_nxt;
  logic rack_ok, rack_ok_nxt, gc, gc_nxt;
  logic [PW-1:0] pointer, pointer_nxt, wr_index_nxt;
  logic sda_oe_nxt, busy_nxt, wr_strobe_nxt, stop_det_nxt, reg_we;
  logic [7:0] rd_byte;
  logic addr_match, gc_match;

  assign host_rdata = regs[host_addr];
  assign rd_byte    = regs[pointer];
  assign addr_match = (shift[7:1] == SLAVE_ADDR);
`ifdef I2C_TARGET_GENERAL_CALL_EN
  assign gc_match   = (shift == 8'h00);
`else
  assign gc_match   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      tx        <= '0;
      byte_done <= 1'b0;
      ack_phase <= 1'b0;
      rack_ok   <= 1'b0;
      gc        <= 1'b0;
      pointer   <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
      stop_det  <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      tx        <= tx_nxt;
      byte_done <= byte_done_nxt;
      ack_phase <= ack_phase_nxt;
      rack_ok   <= rack_ok_nxt;
      gc        <= gc_nxt;
      pointer   <= pointer_nxt;
      sda_oe    <= sda_oe_nxt;
      busy      <= busy_nxt;
      wr_strobe <= wr_strobe_nxt;
      wr_index  <= wr_index_nxt;
      stop_det  <= stop_det_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[pointer] <= shift;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shift_nxt     = shift;
    tx_nxt        = tx;
    byte_done_nxt = byte_done;
    ack_phase_nxt = ack_phase;
    rack_ok_nxt   = rack_ok;
    gc_nxt        = gc;
    pointer_nxt   = pointer;
    sda_oe_nxt    = sda_oe;
    busy_nxt      = busy;
    wr_strobe_nxt = 1'b0;
    wr_index_nxt  = wr_index;
    stop_det_nxt  = 1'b0;
    reg_we        = 1'b0;

    if (stop_cond) begin
      state_nxt     = IDLE;
      sda_oe_nxt    = 1'b0;
      busy_nxt      = 1'b0;
      stop_det_nxt  = 1'b1;
      bit_cnt_nxt   = '0;
      byte_done_nxt = 1'b0;
      ack_phase_nxt = 1'b0;
      rack_ok_nxt   = 1'b0;
      gc_nxt        = 1'b0;
    end else if (start_cond) begin
      // sda_oe is left alone here; it is released on the next SCL fall in ADDR
      state_nxt     = ADDR;
      bit_cnt_nxt   = '0;
      byte_done_nxt = 1'b0;
      ack_phase_nxt = 1'b0;
      rack_ok_nxt   = 1'b0;
      gc_nxt        = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WDATA: begin
          if (scl_rise && !ack_phase && !byte_done) begin
            shift_nxt     = {shift[6:0], sda_s};
            bit_cnt_nxt   = bit_cnt + 3'd1;
            byte_done_nxt = (bit_cnt == 3'd7);
          end else if (scl_fall) begin
            if (byte_done) begin
              byte_done_nxt = 1'b0;
              ack_phase_nxt = 1'b1;
              sda_oe_nxt    = 1'b1;
              if (state == ADDR) begin
                if (addr_match || gc_match) begin
                  busy_nxt = 1'b1;
                  gc_nxt   = gc_match;
                end else begin
                  state_nxt     = IGNORE;
                  busy_nxt      = 1'b0;
                  ack_phase_nxt = 1'b0;
                  sda_oe_nxt    = 1'b0;
                end
              end else if (state == PTR) begin
                pointer_nxt = shift[PW-1:0];
              end else if (!gc) begin
                reg_we        = 1'b1;
                wr_strobe_nxt = 1'b1;
                wr_index_nxt  = pointer;
                pointer_nxt   = pointer + PW'(1);
              end
            end else if (ack_phase) begin
              ack_phase_nxt = 1'b0;
              bit_cnt_nxt   = '0;
              sda_oe_nxt    = 1'b0;
              if (state == ADDR) begin
                if (gc) begin
                  state_nxt = WDATA;
                end else if (shift[0]) begin
                  state_nxt  = RDATA;
                  tx_nxt     = rd_byte;
                  sda_oe_nxt = ~rd_byte[7];
                end else begin
                  state_nxt = PTR;
                end
              end else begin
                state_nxt = WDATA;
              end
            end else begin
              sda_oe_nxt = 1'b0;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_nxt   = bit_cnt + 3'd1;
            byte_done_nxt = (bit_cnt == 3'd7);
          end else if (scl_fall) begin
            if (byte_done) begin
              byte_done_nxt = 1'b0;
              sda_oe_nxt    = 1'b0;
              rack_ok_nxt   = 1'b0;
              state_nxt     = RACK;
            end else begin
              tx_nxt     = {tx[6:0], 1'b0};
              sda_oe_nxt = ~tx[6];
            end
          end
        end
        RACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              rack_ok_nxt = 1'b1;
              pointer_nxt = pointer + PW'(1);
            end else begin
              state_nxt = IGNORE;
              busy_nxt  = 1'b0;
            end
          end else if (scl_fall && rack_ok) begin
            state_nxt   = RDATA;
            rack_ok_nxt = 1'b0;
            bit_cnt_nxt = '0;
            tx_nxt      = rd_byte;
            sda_oe_nxt  = ~rd_byte[7];
          end
        end
        IGNORE: begin
          if (scl_fall) sda_oe_nxt = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
